// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_arb_pkg
// Description : Shared types and default parameter values for the frame-buffer
//               read arbiter and its prefetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_arb_pkg;

   // Prefetch sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam int DEF_ADDR_W       = 19;
   localparam int DEF_DATA_W       = 24;
   localparam int DEF_FRAME_PIXELS = 307200;
   localparam int DEF_FIFO_DEPTH   = 16;
   localparam int DEF_RD_LAT       = 2;
   localparam int DEF_LO_WM        = 4;

endpackage
`default_nettype wire

// File: rtl/fb_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_prefetch_fifo
// Description : Synchronous show-ahead FIFO holding prefetched display pixels.
//               Head is presented combinationally; zero when empty. Flush
//               overrides push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_prefetch_fifo #(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [LVL_W-1:0]  level,
   output logic              empty
);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push;
   logic              do_pop;

   // Pointer and occupancy update; pop on empty and push on full are ignored
   always_comb begin
      do_push  = push && !flush && (level_q != LVL_W'(DEPTH));
      do_pop   = pop && !flush && (level_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
         else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
      end
   end

   // Control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign empty = (level_q == '0);
   assign level = level_q;
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_read_arbiter
// Description : Shares a single-port frame buffer between a frame writer and
//               a sequential display prefetcher feeding a show-ahead FIFO.
//               Read grants are based on FIFO level plus reads in flight so
//               the FIFO can never overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_read_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int RD_LAT       = DEF_RD_LAT,
   parameter int LO_WM        = DEF_LO_WM
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          frame_start,
   input  logic                          pix_rd,
   output logic [DATA_W-1:0]             pix_data,
   output logic                          pix_underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   input  logic                          wr_req,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_ack,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CMT_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              wr_ack_q, wr_ack_d;
   logic              underrun_q, underrun_d;

   logic              rd_issue;
   logic [CMT_W-1:0]  committed;
   logic              grant_rd;
   logic              grant_wr;
   logic [LVL_W-1:0]  fifo_level_w;
   logic              fifo_empty;

   // A read currently on the memory bus is the youngest in-flight read
   assign rd_issue = mem_en_q && !mem_we_q;

   // Committed level: FIFO occupancy plus every read not yet pushed
   always_comb begin
      committed = CMT_W'(fifo_level_w) + CMT_W'(rd_issue);
      for (int i = 0; i < RD_LAT; i++) begin
         committed = committed + CMT_W'(vld_q[i]);
      end
   end

   // Arbitration, address counter and prefetch state sequencing
   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wr_ack_d    = 1'b0;
      grant_rd    = 1'b0;
      grant_wr    = 1'b0;
      if (frame_start) begin
         state_d   = RUN;
         rd_addr_d = '0;
      end else begin
         if (state_q == RUN && committed < CMT_W'(LO_WM)) begin
            grant_rd = 1'b1;
         end else if (wr_req && !wr_ack_q) begin
            grant_wr = 1'b1;
         end else if (state_q == RUN && committed < CMT_W'(FIFO_DEPTH)) begin
            grant_rd = 1'b1;
         end
         if (grant_wr) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            wr_ack_d    = 1'b1;
         end
         if (grant_rd) begin
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr_q;
            rd_addr_d  = rd_addr_q + ADDR_W'(1);
            if (rd_addr_q == ADDR_W'(FRAME_PIXELS - 1)) state_d = DONE;
         end
      end
   end

   // Read-latency valid pipe and sticky underrun; frame_start kills both
   always_comb begin
      vld_d      = '0;
      underrun_d = underrun_q;
      if (frame_start) begin
         underrun_d = 1'b0;
      end else begin
         vld_d[0] = rd_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
         end
         if (pix_rd && fifo_empty) underrun_d = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         vld_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wr_ack_q    <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         vld_q       <= vld_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wr_ack_q    <= wr_ack_d;
         underrun_q  <= underrun_d;
      end
   end

   fb_prefetch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (frame_start),
      .push      (vld_q[RD_LAT-1]),
      .push_data (mem_rdata),
      .pop       (pix_rd),
      .head      (pix_data),
      .level     (fifo_level_w),
      .empty     (fifo_empty)
   );

   assign fifo_level   = fifo_level_w;
   assign pix_underrun = underrun_q;
   assign wr_ack       = wr_ack_q;
   assign mem_en       = mem_en_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;

endmodule
`default_nettype wire
